// File: rtl/pipeline_hazard_fwd_if.sv
// rtl/pipeline_hazard_fwd_if.sv - issue-stage bundle between read-register stage and hazard controller
//
// Carries the instruction tag presented at issue, its three source operand
// requests (packed {Rd,Rn,Rm}, Rm in the low slice) and the controller's
// resolved operands and stall/accept handshake.
//   master : read-register stage (drives tag and source requests)
//   slave  : pipeline_hazard_fwd (drives opnd_data, stall, issue_accept)
interface pipeline_hazard_fwd_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
);
    logic                  issue_valid;
    logic                  issue_write;
    logic [REG_W-1:0]      issue_writenum;
    logic                  issue_load;
    logic [3*REG_W-1:0]    src_num;
    logic [2:0]            src_used;
    logic [3*DATA_W-1:0]   src_regdata;
    logic [3*DATA_W-1:0]   opnd_data;
    logic                  stall;
    logic                  issue_accept;

    modport master (
        output issue_valid, issue_write, issue_writenum, issue_load,
        output src_num, src_used, src_regdata,
        input  opnd_data, stall, issue_accept
    );

    modport slave (
        input  issue_valid, issue_write, issue_writenum, issue_load,
        input  src_num, src_used, src_regdata,
        output opnd_data, stall, issue_accept
    );
endinterface

// File: rtl/pipeline_hazard_fwd.sv
// rtl/pipeline_hazard_fwd.sv - in-order pipeline hazard detection and operand forwarding
//
// Tracks the destination tag of every instruction through DEPTH stages after
// issue (entry 1 = execute output, entry DEPTH = writeback), forwards the
// youngest matching stage result to each used source, and stalls issue while
// a matching load has not yet reached LOAD_STAGE.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   iss             : issue bundle (tag, sources, resolved operands, stall/accept)
//   stage_data      : per-entry result, entry k at [(k-1)*DATA_W +: DATA_W]
//   flush           : branch redirect, drops issue and kills entries 1..FLUSH_DEPTH
//   wb_write/wb_num : tag of the entry in writeback
//   inflight_write  : per-entry valid & write, bit k-1 = entry k
//   stall_count     : saturating count of stall cycles not overridden by flush
module pipeline_hazard_fwd #(
    parameter int DATA_W      = 16,
    parameter int REG_W       = 3,
    parameter int DEPTH       = 3,
    parameter int LOAD_STAGE  = 3,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    pipeline_hazard_fwd_if.slave     iss,
    input  logic [DEPTH*DATA_W-1:0]  stage_data,
    input  logic                     flush,
    output logic                     wb_write,
    output logic [REG_W-1:0]         wb_num,
    output logic [DEPTH-1:0]         inflight_write,
    output logic [CNT_W-1:0]         stall_count
);

    // Tag pipeline, index k-1 holds entry k.
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0]            write_q, write_d;
    logic [DEPTH-1:0]            load_q,  load_d;
    logic [DEPTH-1:0][REG_W-1:0] num_q,   num_d;
    logic [CNT_W-1:0]            stall_cnt_q, stall_cnt_d;

    logic [2:0]                  hazard;
    logic [3*DATA_W-1:0]         opnd_w;
    logic                        stall_w;
    logic                        accept_w;

    // Operand resolve. Entries are scanned oldest to youngest so the last
    // match written, i.e. the youngest producer, wins.
    always_comb begin
        opnd_w = iss.src_regdata;
        hazard = '0;
        for (int s = 0; s < 3; s++) begin
            if (iss.src_used[s]) begin
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (valid_q[k] && write_q[k] &&
                        (num_q[k] == iss.src_num[s*REG_W +: REG_W])) begin
                        if (load_q[k] && (k + 1 < LOAD_STAGE)) begin
                            // Load data not available yet; operand is a don't-care.
                            hazard[s]                    = 1'b1;
                            opnd_w[s*DATA_W +: DATA_W]   = iss.src_regdata[s*DATA_W +: DATA_W];
                        end else begin
                            hazard[s]                    = 1'b0;
                            opnd_w[s*DATA_W +: DATA_W]   = stage_data[k*DATA_W +: DATA_W];
                        end
                    end
                end
            end
        end
    end

    assign stall_w  = iss.issue_valid & (|hazard);
    assign accept_w = iss.issue_valid & ~stall_w & ~flush;

    // Next tag state: unconditional shift, bubbles carry all-zero fields.
    always_comb begin
        valid_d = '0;
        write_d = '0;
        load_d  = '0;
        num_d   = '0;
        if (accept_w) begin
            valid_d[0] = 1'b1;
            write_d[0] = iss.issue_write;
            load_d[0]  = iss.issue_load;
            num_d[0]   = iss.issue_writenum;
        end
        // Destination index k (entry k+1) receives entry k; flush kills the
        // youngest FLUSH_DEPTH entries as they move.
        for (int k = 1; k < DEPTH; k++) begin
            if (!(flush && (k <= FLUSH_DEPTH))) begin
                valid_d[k] = valid_q[k-1];
                write_d[k] = write_q[k-1];
                load_d[k]  = load_q[k-1];
                num_d[k]   = num_q[k-1];
            end
        end
    end

    // A stall overridden by flush is not counted.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_w && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            write_q     <= '0;
            load_q      <= '0;
            num_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            write_q     <= write_d;
            load_q      <= load_d;
            num_q       <= num_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign iss.opnd_data    = opnd_w;
    assign iss.stall        = stall_w;
    assign iss.issue_accept = accept_w;
    assign wb_write         = valid_q[DEPTH-1] & write_q[DEPTH-1];
    assign wb_num           = num_q[DEPTH-1];
    assign inflight_write   = valid_q & write_q;
    assign stall_count      = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_fwd.sv
// tb/tb_pipeline_hazard_fwd.sv - self-checking bench for pipeline_hazard_fwd
module tb_pipeline_hazard_fwd;

    localparam int DW = 16;
    localparam int RW = 3;
    localparam int DP = 3;
    localparam int LS = 3;
    localparam int FD = 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic [DP*DW-1:0]   stage_data;
    logic               wb_write_a, wb_write_b;
    logic [RW-1:0]      wb_num_a, wb_num_b;
    logic [DP-1:0]      inflight_a, inflight_b;
    logic [15:0]        cnt_a;
    logic [1:0]         cnt_b;

    always #5 clk = ~clk;

    pipeline_hazard_fwd_if #(.DATA_W(DW), .REG_W(RW)) ifa ();
    pipeline_hazard_fwd_if #(.DATA_W(DW), .REG_W(RW)) ifb ();

    assign ifb.issue_valid    = ifa.issue_valid;
    assign ifb.issue_write    = ifa.issue_write;
    assign ifb.issue_writenum = ifa.issue_writenum;
    assign ifb.issue_load     = ifa.issue_load;
    assign ifb.src_num        = ifa.src_num;
    assign ifb.src_used       = ifa.src_used;
    assign ifb.src_regdata    = ifa.src_regdata;

    pipeline_hazard_fwd #(.DATA_W(DW), .REG_W(RW), .DEPTH(DP), .LOAD_STAGE(LS),
                          .FLUSH_DEPTH(FD), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .iss(ifa.slave), .stage_data(stage_data), .flush(flush),
        .wb_write(wb_write_a), .wb_num(wb_num_a), .inflight_write(inflight_a),
        .stall_count(cnt_a));

    pipeline_hazard_fwd #(.DATA_W(DW), .REG_W(RW), .DEPTH(DP), .LOAD_STAGE(LS),
                          .FLUSH_DEPTH(FD), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .iss(ifb.slave), .stage_data(stage_data), .flush(flush),
        .wb_write(wb_write_b), .wb_num(wb_num_b), .inflight_write(inflight_b),
        .stall_count(cnt_b));

    // Reference model: list of in-flight tags, position 1 = youngest.
    bit       m_valid [1:DP];
    bit       m_write [1:DP];
    bit       m_load  [1:DP];
    int       m_num   [1:DP];
    int       m_cnt;
    int       m_cnt2;
    bit       e_stall, e_acc;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Half a cycle after inputs settle: derive expectations and compare.
    task automatic settle();
        logic [3*DW-1:0] e_opnd;
        logic [DP-1:0]   e_infl;
        bit              haz;
        bit              found;
        #4;
        haz = 0;
        for (int s = 0; s < 3; s++) begin
            logic [DW-1:0] v;
            int            want;
            v     = ifa.src_regdata[s*DW +: DW];
            want  = int'(ifa.src_num[s*RW +: RW]);
            found = 0;
            if (ifa.src_used[s]) begin
                for (int k = 1; k <= DP; k++) begin
                    if (!found && m_valid[k] && m_write[k] && m_num[k] == want) begin
                        found = 1;
                        if (m_load[k] && k < LS) haz = 1;
                        else v = stage_data[(k-1)*DW +: DW];
                    end
                end
            end
            e_opnd[s*DW +: DW] = v;
        end
        e_stall = ifa.issue_valid && haz;
        e_acc   = ifa.issue_valid && !e_stall && !flush;
        for (int k = 1; k <= DP; k++) e_infl[k-1] = m_valid[k] && m_write[k];

        chk("opnd_data", ifa.opnd_data, e_opnd);
        chk("stall", ifa.stall, e_stall);
        chk("issue_accept", ifa.issue_accept, e_acc);
        chk("wb_write", wb_write_a, m_valid[DP] && m_write[DP]);
        if (m_valid[DP] && m_write[DP]) chk("wb_num", wb_num_a, m_num[DP]);
        chk("inflight_write", inflight_a, e_infl);
        chk("stall_count", cnt_a, m_cnt);
        chk("stall_count_sat", cnt_b, m_cnt2);
        chk("stall_b", ifb.stall, e_stall);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            for (int k = 1; k <= DP; k++) begin
                m_valid[k] = 0; m_write[k] = 0; m_load[k] = 0; m_num[k] = 0;
            end
            m_cnt  = 0;
            m_cnt2 = 0;
        end else begin
            if (e_stall && !flush) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            for (int k = DP; k >= 2; k--) begin
                if (flush && (k - 1) <= FD) begin
                    m_valid[k] = 0; m_write[k] = 0; m_load[k] = 0; m_num[k] = 0;
                end else begin
                    m_valid[k] = m_valid[k-1]; m_write[k] = m_write[k-1];
                    m_load[k]  = m_load[k-1];  m_num[k]   = m_num[k-1];
                end
            end
            m_valid[1] = e_acc;
            m_write[1] = e_acc && ifa.issue_write;
            m_load[1]  = e_acc && ifa.issue_load;
            m_num[1]   = e_acc ? int'(ifa.issue_writenum) : 0;
        end
        #1;
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    task automatic idle();
        ifa.issue_valid    = 0;
        ifa.issue_write    = 0;
        ifa.issue_writenum = '0;
        ifa.issue_load     = 0;
        ifa.src_num        = '0;
        ifa.src_used       = '0;
        ifa.src_regdata    = '0;
        stage_data         = '0;
        flush              = 0;
        rst                = 0;
    endtask

    task automatic iss(input bit w, input int num, input bit ld);
        ifa.issue_valid    = 1;
        ifa.issue_write    = w;
        ifa.issue_writenum = RW'(num);
        ifa.issue_load     = ld;
    endtask

    task automatic src(input int s, input int num);
        ifa.src_num[s*RW +: RW] = RW'(num);
        ifa.src_used[s]         = 1'b1;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < DP; i++) cyc();
    endtask

    initial begin
        for (int k = 1; k <= DP; k++) begin
            m_valid[k] = 0; m_write[k] = 0; m_load[k] = 0; m_num[k] = 0;
        end
        m_cnt = 0; m_cnt2 = 0;
        idle();
        rst = 1;
        ifa.src_regdata = 48'h1111_2222_3333;
        #1;
        advance();
        advance();
        // Reset state.
        settle();
        chk("rst_stall", ifa.stall, 1'b0);
        chk("rst_wb_write", wb_write_a, 1'b0);
        chk("rst_wb_num", wb_num_a, 3'd0);
        chk("rst_inflight", inflight_a, 3'b000);
        chk("rst_cnt", cnt_a, 16'd0);
        chk("rst_opnd", ifa.opnd_data, 48'h1111_2222_3333);
        advance();
        drain();

        // Forward from execute output.
        idle(); iss(1, 2, 0); cyc();
        idle(); iss(0, 0, 0); src(0, 2);
        stage_data[15:0] = 16'h1234;
        settle();
        chk("t1_opnd_rm", ifa.opnd_data[15:0], 16'h1234);
        chk("t1_stall", ifa.stall, 1'b0);
        chk("t1_accept", ifa.issue_accept, 1'b1);
        advance();
        drain();

        // Load-use stall for two cycles then forward from entry 3.
        idle(); iss(1, 5, 1); cyc();
        for (int c = 0; c < 2; c++) begin
            idle(); iss(0, 0, 0); src(1, 5);
            settle();
            chk("t2_stall", ifa.stall, 1'b1);
            advance();
        end
        idle(); iss(0, 0, 0); src(1, 5);
        stage_data[47:32] = 16'hBEEF;
        settle();
        chk("t2_stall_clear", ifa.stall, 1'b0);
        chk("t2_opnd_rn", ifa.opnd_data[31:16], 16'hBEEF);
        chk("t2_cnt", cnt_a, 16'd2);
        advance();
        drain();

        // Youngest producer wins.
        idle(); iss(1, 1, 0); cyc();
        idle(); iss(1, 1, 0); cyc();
        idle(); iss(0, 0, 0); src(2, 1);
        stage_data[15:0] = 16'hAAAA; stage_data[31:16] = 16'hBBBB;
        settle();
        chk("t3_opnd_rd", ifa.opnd_data[47:32], 16'hAAAA);
        advance();
        drain();

        // Flush kills entry 1 but not the older write in entry 2.
        idle(); iss(1, 4, 0); cyc();
        idle(); iss(1, 3, 0); cyc();
        idle(); iss(1, 6, 0); flush = 1;
        settle();
        chk("t4_accept", ifa.issue_accept, 1'b0);
        advance();
        idle(); settle();
        chk("t4_wb_write_c2", wb_write_a, 1'b1);
        chk("t4_wb_num_c2", wb_num_a, 3'd4);
        advance();
        idle(); settle();
        chk("t4_wb_write_c3", wb_write_a, 1'b0);
        advance();
        idle(); settle();
        chk("t4_wb_write_c4", wb_write_a, 1'b0);
        advance();
        drain();

        // Reset in the middle of a stall.
        idle(); iss(1, 5, 1); cyc();
        idle(); iss(0, 0, 0); src(1, 5); rst = 1;
        settle();
        chk("t5_stall_pre", ifa.stall, 1'b1);
        advance();
        rst = 0;
        settle();
        chk("t5_stall", ifa.stall, 1'b0);
        chk("t5_cnt", cnt_a, 16'd0);
        chk("t5_wb_write", wb_write_a, 1'b0);
        chk("t5_inflight", inflight_a, 3'b000);
        advance();
        drain();

        // Unused source ignores a matching load.
        idle(); iss(1, 5, 1); cyc();
        idle(); iss(0, 0, 0); ifa.src_num[5:3] = 3'd5; ifa.src_regdata[31:16] = 16'h7777;
        settle();
        chk("t6_stall", ifa.stall, 1'b0);
        chk("t6_opnd", ifa.opnd_data[31:16], 16'h7777);
        advance();
        drain();

        // Five stall cycles: narrow counter saturates.
        for (int r = 0; r < 3; r++) begin
            idle(); iss(1, 5, 1); cyc();
            for (int c = 0; c < ((r == 2) ? 1 : 2); c++) begin
                idle(); iss(0, 0, 0); src(1, 5); cyc();
            end
            idle(); cyc();
        end
        settle();
        chk("t6_cnt_wide", cnt_a, 16'd5);
        chk("t6_cnt_sat", cnt_b, 2'd3);
        advance();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            ifa.issue_valid    = ($urandom_range(0, 3) != 0);
            ifa.issue_write    = ($urandom_range(0, 3) != 0);
            ifa.issue_writenum = RW'($urandom_range(0, 7));
            ifa.issue_load     = ($urandom_range(0, 2) == 0);
            ifa.src_num        = (3*RW)'($urandom);
            ifa.src_used       = 3'($urandom);
            ifa.src_regdata    = {16'($urandom), 32'($urandom)};
            stage_data         = {16'($urandom), 32'($urandom)};
            flush              = ($urandom_range(0, 9) == 0);
            rst                = ($urandom_range(0, 63) == 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
